// File: rtl/slice_serial_alu.sv
// Slice-serial ALU: evaluates a WIDTH-bit operation SLICE bits per clock, LSB slice first.
// Optional compare ops: define SLICE_ALU_SLT_EN to implement SLT/SLTU on Op 5/6 (otherwise they act as SUB).
module slice_serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic [2:0]       Op,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutC,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_SLTU  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % SLICE) != 0) begin : gBadSlice
            $error("slice_serial_alu: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       stateR;
    logic [CW-1:0]    cntR;
    logic [WIDTH-1:0] aR, bR, resR;
    logic [2:0]       opR;
    logic             carryR, msbCarryR;

    logic [2:0]       opDecS;
    logic             invDecS, invS, acceptS, lastS, msbCinS, ovS;
    logic [SLICE-1:0] aSlS, bSlS, bEffS, sliceS;
    logic [SLICE:0]   sumS;
    logic [WIDTH-1:0] resNextS, fCS;
    logic             fCoS, fOvS;

    assign acceptS = InValid & InReady & ~Flush;
    assign lastS   = (cntR == CW'(N - 1));

    // Operation decode at accept; compare ops fold onto SUB when the compare feature is absent
    always_comb begin
`ifdef SLICE_ALU_SLT_EN
        opDecS = Op;
`else
        if ((Op == OP_SLT) || (Op == OP_SLTU)) begin
            opDecS = OP_SUB;
        end else begin
            opDecS = Op;
        end
`endif
        invDecS = (opDecS == OP_SUB) || (opDecS == OP_SLT) || (opDecS == OP_SLTU);
    end

    // One slice of the datapath; operand regs shift right so slice k is always at the bottom
    always_comb begin
        invS    = (opR == OP_SUB) || (opR == OP_SLT) || (opR == OP_SLTU);
        aSlS    = aR[SLICE-1:0];
        bSlS    = bR[SLICE-1:0];
        bEffS   = invS ? ~bSlS : bSlS;
        sumS    = {1'b0, aSlS} + {1'b0, bEffS} + {{SLICE{1'b0}}, carryR};
        msbCinS = sumS[SLICE-1] ^ aSlS[SLICE-1] ^ bEffS[SLICE-1];
        case (opR)
            OP_AND:   sliceS = aSlS & bSlS;
            OP_OR:    sliceS = aSlS | bSlS;
            OP_XOR:   sliceS = aSlS ^ bSlS;
            OP_PASSB: sliceS = bSlS;
            default:  sliceS = sumS[SLICE-1:0];
        endcase
        resNextS = WIDTH'({sliceS, resR} >> SLICE);
    end

    // Final result and flags from the completed result register and the last slice carries
    always_comb begin
        ovS = carryR ^ msbCarryR;
        case (opR)
            OP_ADD, OP_SUB: begin
                fCS  = resR;
                fCoS = carryR;
                fOvS = ovS;
            end
`ifdef SLICE_ALU_SLT_EN
            OP_SLT: begin
                fCS  = {{(WIDTH-1){1'b0}}, resR[WIDTH-1] ^ ovS};
                fCoS = carryR;
                fOvS = 1'b0;
            end
            OP_SLTU: begin
                fCS  = {{(WIDTH-1){1'b0}}, ~carryR};
                fCoS = carryR;
                fOvS = 1'b0;
            end
`endif
            default: begin
                fCS  = resR;
                fCoS = 1'b0;
                fOvS = 1'b0;
            end
        endcase
    end

    // Control FSM, slice datapath registers and registered result/handshake outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stateR    <= IDLE;
            cntR      <= '0;
            aR        <= '0;
            bR        <= '0;
            resR      <= '0;
            opR       <= 3'd0;
            carryR    <= 1'b0;
            msbCarryR <= 1'b0;
            InReady   <= 1'b1;
            OutValid  <= 1'b0;
            OutC      <= '0;
            CarryOut  <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        aR        <= InA;
                        bR        <= InB;
                        opR       <= opDecS;
                        carryR    <= invDecS;
                        msbCarryR <= 1'b0;
                        resR      <= '0;
                        cntR      <= '0;
                        InReady   <= 1'b0;
                        stateR    <= RUN;
                    end else begin
                        stateR <= IDLE;
                    end
                end
                RUN: begin
                    if (Flush) begin
                        cntR    <= '0;
                        InReady <= 1'b1;
                        stateR  <= IDLE;
                    end else begin
                        aR        <= aR >> SLICE;
                        bR        <= bR >> SLICE;
                        resR      <= resNextS;
                        carryR    <= sumS[SLICE];
                        msbCarryR <= msbCinS;
                        if (lastS) begin
                            cntR   <= '0;
                            stateR <= DONE;
                        end else begin
                            cntR <= cntR + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (Flush) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        stateR   <= IDLE;
                    end else if (!OutValid) begin
                        OutValid <= 1'b1;
                        OutC     <= fCS;
                        CarryOut <= fCoS;
                        Overflow <= fOvS;
                        Zero     <= (fCS == {WIDTH{1'b0}});
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        stateR   <= IDLE;
                    end else begin
                        stateR <= DONE;
                    end
                end
                default: begin
                    OutValid <= 1'b0;
                    InReady  <= 1'b1;
                    stateR   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slice_serial_alu.sv
// Self-checking bench for slice_serial_alu (WIDTH=32, SLICE=8); results checked by a queue scoreboard.
module tb_slice_serial_alu;
    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic         Clock, ResetN, InValid, InReady, Flush, OutValid, OutReady;
    logic [W-1:0] InA, InB, OutC;
    logic [2:0]   Op;
    logic         CarryOut, Overflow, Zero;

    typedef struct packed {
        logic [W-1:0] c;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   nCmp = 0;
    int   nErr = 0;

    slice_serial_alu #(.WIDTH(W), .SLICE(S)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .Op(Op), .Flush(Flush), .OutValid(OutValid),
        .OutReady(OutReady), .OutC(OutC), .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t e;
        logic [W:0] s;
        logic [2:0] o;
        o = op;
`ifndef SLICE_ALU_SLT_EN
        if (o == 3'd5 || o == 3'd6) o = 3'd1;
`endif
        e = '0;
        case (o)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                e.c = s[W-1:0]; e.co = s[W];
                e.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.c = s[W-1:0]; e.co = s[W];
                e.ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'd2: e.c = a & b;
            3'd3: e.c = a | b;
            3'd4: e.c = a ^ b;
            3'd5: begin e.c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.co = (a >= b); end
            3'd6: begin e.c = (a < b) ? 32'd1 : 32'd0; e.co = (a >= b); end
            default: e.c = b;
        endcase
        e.z = (e.c == 32'd0);
        return e;
    endfunction

    // scoreboard: pop and compare on every completed output handshake
    always @(negedge Clock) begin : sb
        exp_t e;
        if (ResetN && OutValid && OutReady) begin
            nCmp++;
            if (q.size() == 0) begin
                nErr++;
                $display("FAIL sb_unexpected: got OutC=%h with no expected result queued", OutC);
            end else begin
                e = q.pop_front();
                if ({OutC, CarryOut, Overflow, Zero} !== e) begin
                    nErr++;
                    $display("FAIL sb_result: got C=%h co=%b ov=%b z=%b, want C=%h co=%b ov=%b z=%b",
                             OutC, CarryOut, Overflow, Zero, e.c, e.co, e.ov, e.z);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit push);
        int t = 0;
        InA = a; InB = b; Op = op; InValid = 1'b1;
        while (!InReady && t < 20) begin
            @(posedge Clock); #1; t++;
        end
        nCmp++;
        if (t >= 20) begin
            nErr++;
            $display("FAIL accept_timeout: InReady=%b after %0d cycles, want 1", InReady, t);
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
        InA = $urandom; InB = $urandom; Op = 3'($urandom_range(0, 7));
        if (push) q.push_back(model(a, b, op));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!OutValid && lat < 20) begin
            @(posedge Clock); #1; lat++;
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        InA = '0; InB = '0; Op = 3'd0;
        #12;
        nCmp++;
        if ({InReady, OutValid, OutC, CarryOut, Overflow, Zero} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            nErr++;
            $display("FAIL reset_state: got rdy=%b vld=%b C=%h flags=%b%b%b, want rdy=1 vld=0 C=0 flags=000",
                     InReady, OutValid, OutC, CarryOut, Overflow, Zero);
        end
        @(posedge Clock); #1;
        ResetN = 1'b1;
    endtask

    task automatic test_add_carry();
        int lat;
        OutReady = 1'b1;
        issue(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b1);
        wait_out(lat);
        nCmp++;
        if (lat !== N + 1) begin nErr++; $display("FAIL add_latency: got %0d, want %0d", lat, N + 1); end
        nCmp++;
        if ({OutC, CarryOut, Zero, Overflow} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
            nErr++;
            $display("FAIL add_wrap: got C=%h co=%b z=%b ov=%b, want C=0 co=1 z=1 ov=0", OutC, CarryOut, Zero, Overflow);
        end
        @(posedge Clock); #1;
        nCmp++;
        if ({OutValid, InReady} !== 2'b01) begin
            nErr++;
            $display("FAIL add_release: got vld=%b rdy=%b, want vld=0 rdy=1", OutValid, InReady);
        end
    endtask

    task automatic test_sub_overflow();
        int lat = 0;
        int lowCnt = 0;
        issue(32'h8000_0000, 32'h1, 3'd1, 1'b1);
        while (!OutValid && lat < 20) begin
            if (!InReady) lowCnt++;
            @(posedge Clock); #1; lat++;
        end
        nCmp++;
        if (lowCnt !== N + 1) begin nErr++; $display("FAIL sub_ready_low: got %0d cycles, want %0d", lowCnt, N + 1); end
        nCmp++;
        if ({OutC, Overflow, CarryOut} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
            nErr++;
            $display("FAIL sub_ovf: got C=%h ov=%b co=%b, want C=7fffffff ov=1 co=1", OutC, Overflow, CarryOut);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_slt();
        int lat;
        logic [W-1:0] wantSlt, wantSltu;
`ifdef SLICE_ALU_SLT_EN
        wantSlt = 32'd1; wantSltu = 32'd0;
`else
        wantSlt = 32'hFFFF_FFFE; wantSltu = 32'hFFFF_FFFE;
`endif
        issue(32'hFFFF_FFFF, 32'h1, 3'd5, 1'b1);
        wait_out(lat);
        nCmp++;
        if (OutC !== wantSlt) begin nErr++; $display("FAIL slt_result: got %h, want %h", OutC, wantSlt); end
        @(posedge Clock); #1;
        issue(32'hFFFF_FFFF, 32'h1, 3'd6, 1'b1);
        wait_out(lat);
        nCmp++;
        if (OutC !== wantSltu) begin nErr++; $display("FAIL sltu_result: got %h, want %h", OutC, wantSltu); end
        @(posedge Clock); #1;
    endtask

    task automatic test_hold();
        int lat;
        bit ok = 1'b1;
        OutReady = 1'b0;
        issue(32'h1234_5678, 32'h0F0F_0F0F, 3'd4, 1'b1);
        wait_out(lat);
        repeat (3) begin
            @(posedge Clock); #1;
            if (!(OutValid === 1'b1 && OutC === 32'h1D3B_5977)) ok = 1'b0;
        end
        nCmp++;
        if (!ok) begin nErr++; $display("FAIL hold_stable: got vld=%b C=%h, want vld=1 C=1d3b5977", OutValid, OutC); end
        OutReady = 1'b1;
        @(posedge Clock); #1;
        nCmp++;
        if ({OutValid, InReady} !== 2'b01) begin
            nErr++;
            $display("FAIL hold_release: got vld=%b rdy=%b, want vld=0 rdy=1", OutValid, InReady);
        end
        issue(32'hA5A5_0000, 32'h0000_5A5A, 3'd3, 1'b1);
        wait_out(lat);
        nCmp++;
        if (lat !== N + 1) begin nErr++; $display("FAIL hold_next_latency: got %0d, want %0d", lat, N + 1); end
        @(posedge Clock); #1;
    endtask

    task automatic test_flush();
        int lat;
        bit seen = 1'b0;
        OutReady = 1'b1;
        issue(32'h1111_1111, 32'h2222_2222, 3'd0, 1'b0);
        @(posedge Clock); #1;
        Flush = 1'b1;
        @(posedge Clock); #1;
        Flush = 1'b0;
        nCmp++;
        if ({InReady, OutValid} !== 2'b10) begin
            nErr++;
            $display("FAIL flush_run: got rdy=%b vld=%b, want rdy=1 vld=0", InReady, OutValid);
        end
        repeat (8) begin
            @(posedge Clock); #1;
            if (OutValid) seen = 1'b1;
        end
        nCmp++;
        if (seen !== 1'b0) begin nErr++; $display("FAIL flush_no_out: got OutValid seen=%b, want 0", seen); end
        InValid = 1'b1; Flush = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0; Flush = 1'b0;
        nCmp++;
        if (InReady !== 1'b1) begin nErr++; $display("FAIL flush_priority: got rdy=%b, want 1", InReady); end
        OutReady = 1'b0;
        issue(32'd5, 32'd6, 3'd0, 1'b0);
        wait_out(lat);
        Flush = 1'b1;
        @(posedge Clock); #1;
        Flush = 1'b0;
        nCmp++;
        if ({OutValid, InReady, OutC} !== {1'b0, 1'b1, 32'd11}) begin
            nErr++;
            $display("FAIL flush_done: got vld=%b rdy=%b C=%h, want vld=0 rdy=1 C=b", OutValid, InReady, OutC);
        end
        OutReady = 1'b1;
    endtask

    task automatic test_reset_mid();
        issue(32'h0000_00FF, 32'h0000_0001, 3'd0, 1'b0);
        @(posedge Clock); #1;
        ResetN = 1'b0;
        #1;
        nCmp++;
        if ({OutValid, OutC, CarryOut, Overflow, Zero, InReady} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
            nErr++;
            $display("FAIL reset_mid: got vld=%b C=%h flags=%b%b%b rdy=%b, want vld=0 C=0 flags=000 rdy=1",
                     OutValid, OutC, CarryOut, Overflow, Zero, InReady);
        end
        @(posedge Clock); #1;
        ResetN = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] a, b;
        OutReady = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = (i % 6 == 0) ? 32'h7FFF_FFFF : $urandom;
            b = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            issue(a, b, 3'(i % 8), 1'b1);
            wait_out(lat);
            nCmp++;
            if (lat !== N + 1) begin nErr++; $display("FAIL b2b_latency: op %0d got %0d, want %0d", i, lat, N + 1); end
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_overflow();
        test_slt();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge Clock);
        #1;
        nCmp++;
        if (q.size() !== 0) begin nErr++; $display("FAIL sb_drain: got %0d results outstanding, want 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
